// File: rtl/pc_sequencer.sv
// Program-counter sequencer: drives instruction fetches through IDLE/FETCH/HOLD,
// selects the next PC (jump > branch > sequential) and redirects on exceptions.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] inc_in,
   input  logic [31:0] inc_out,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        jump,
   input  logic [25:0] jump_index,
   input  logic        exception,
   output logic [31:0] pc_out,
   output logic        fetch_valid,
   output logic [31:0] epc,
   output logic [31:0] fetch_cnt
);

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] epc_q, epc_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] next_pc;

   // Redirect selection; only consumed on an updating edge, so nothing is latched.
   always_comb begin
      next_pc = inc_out;
      if (jump) begin
         next_pc = {inc_out[31:28], jump_index, 2'b00};
      end else if (branch_taken) begin
         next_pc = {branch_target[31:2], 2'b00};
      end
   end

   // Next-state, PC update and fetch handshake; exception overrides everything.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      epc_d       = epc_q;
      cnt_d       = cnt_q;
      imem_req    = 1'b0;
      fetch_valid = 1'b0;

      unique case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               fetch_valid = 1'b1;
               if (stall) begin
                  state_d = StHold;
               end else begin
                  pc_d = next_pc;
               end
            end
         end
         StHold: begin
            if (!stall) begin
               pc_d    = next_pc;
               state_d = StFetch;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Pending fetch is abandoned: no delivery pulse, no count.
      if (exception) begin
         state_d     = StFetch;
         pc_d        = EXC_VECTOR;
         epc_d       = pc_q;
         fetch_valid = 1'b0;
      end

      if (fetch_valid) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         pc_q    <= RESET_PC;
         epc_q   <= 32'h0000_0000;
         cnt_q   <= 32'h0000_0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         epc_q   <= epc_d;
         cnt_q   <= cnt_d;
      end
   end

   // All address views are the same registered PC.
   assign pc_out    = pc_q;
   assign imem_addr = pc_q;
   assign inc_in    = pc_q;
   assign epc       = epc_q;
   assign fetch_cnt = cnt_q;

endmodule
